pa_fpu_wbrf: RTL and testbench

- Writeback sink and register file for the FPU result forwarding bus.
- Consumes the single merged result stream (vld/data/fflags plus destination index) and writes it into a 32-entry FP register file.
- Clears the scoreboard busy bit for that destination and accumulates sticky fflags for the CSR.
- Serves IDU operand reads with same-cycle bypass, and owns the in-flight counter and the flush/drain sequence.

---
 rtl/pa_fpu_pkg.sv | 21 ++
 rtl/pa_fpu_wbrf_rdport.sv | 23 ++
 rtl/pa_fpu_wbrf.sv | 173 +++++++++++++++++
 tb/tb_pa_fpu_wbrf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu_pkg.sv
// Shared types and constants for the FPU writeback / register-file slice.
// Optional macro used by this slice: FPU_WBRF_PERF_EN (writeback perf counter).
package pa_fpu_pkg;

    localparam int PA_FPU_FLEN = 32;

    typedef logic [4:0] freg_idx_t;
    typedef logic [4:0] fflags_t;

    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wbrf_state_e;

endpackage

// File: rtl/pa_fpu_wbrf_rdport.sv
// One FP register-file read port: indexed read with same-cycle writeback bypass.
module pa_fpu_wbrf_rdport
    import pa_fpu_pkg::*;
#(
    parameter int FLEN = PA_FPU_FLEN
) (
    input  freg_idx_t        idx_i,
    input  logic [FLEN-1:0]  rf_i [32],
    input  logic [31:0]      busy_i,
    input  logic             wb_en_i,
    input  freg_idx_t        wb_dst_i,
    input  logic [FLEN-1:0]  wb_data_i,
    output logic [FLEN-1:0]  data_o,
    output logic             busy_o
);

    logic hit;

    assign hit    = wb_en_i && (wb_dst_i == idx_i);
    assign data_o = hit ? wb_data_i : rf_i[idx_i];
    assign busy_o = busy_i[idx_i] && !hit;

endmodule

// File: rtl/pa_fpu_wbrf.sv
// FPU writeback sink: FP register file, scoreboard, sticky fflags, in-flight count
// and flush/drain FSM. Define FPU_WBRF_PERF_EN to add the fpu_perf_wb_cnt output.
module pa_fpu_wbrf
    import pa_fpu_pkg::*;
#(
    parameter int FLEN      = PA_FPU_FLEN,
    parameter int NUM_OUTST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idu_fpu_issue_vld,
    input  freg_idx_t        idu_fpu_issue_dst,
    output logic             fpu_idu_issue_rdy,
    input  logic             idu_fpu_flush,
    input  logic             fpu_idu_fwd_vld,
    input  logic [FLEN-1:0]  fpu_idu_fwd_data,
    input  fflags_t          fpu_idu_fwd_fflags,
    input  freg_idx_t        fpu_idu_fwd_dst,
    input  freg_idx_t        idu_fpu_rs1_idx,
    input  freg_idx_t        idu_fpu_rs2_idx,
    input  freg_idx_t        idu_fpu_rs3_idx,
    output logic [FLEN-1:0]  fpu_idu_rs1_data,
    output logic [FLEN-1:0]  fpu_idu_rs2_data,
    output logic [FLEN-1:0]  fpu_idu_rs3_data,
    output logic             fpu_idu_rs1_busy,
    output logic             fpu_idu_rs2_busy,
    output logic             fpu_idu_rs3_busy,
    input  logic             csr_fpu_fflags_wen,
    input  fflags_t          csr_fpu_fflags_wdata,
    output fflags_t          fpu_csr_fflags,
    output logic             fpu_idu_drain
`ifdef FPU_WBRF_PERF_EN
    ,
    output logic [31:0]      fpu_perf_wb_cnt
`endif
);

    localparam int CNT_W = $clog2(NUM_OUTST + 1);

    wbrf_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      busy_q, busy_d;
    fflags_t          fflags_q, fflags_d;
    logic [FLEN-1:0]  rf_q [32];

    logic wb_en;
    logic accept;
    logic rdy;

    assign wb_en  = fpu_idu_fwd_vld && (state_q == IDLE);

    // A matching writeback in the same cycle lifts the WAW stall immediately.
    assign rdy    = (state_q == IDLE) && !idu_fpu_flush
                 && (cnt_q < CNT_W'(NUM_OUTST))
                 && (!busy_q[idu_fpu_issue_dst]
                     || (wb_en && (fpu_idu_fwd_dst == idu_fpu_issue_dst)));
    assign accept = idu_fpu_issue_vld && rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !fpu_idu_fwd_vld) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && fpu_idu_fwd_vld && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[fpu_idu_fwd_dst] = 1'b0;
        end
        if (accept) begin
            busy_d[idu_fpu_issue_dst] = 1'b1;
        end
        if (idu_fpu_flush) begin
            busy_d = '0;
        end
    end

    // CSR write lands first; same-cycle result flags still accumulate on top.
    always_comb begin
        fflags_d = csr_fpu_fflags_wen ? csr_fpu_fflags_wdata : fflags_q;
        if (wb_en) begin
            fflags_d = fflags_d | fpu_idu_fwd_fflags;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (idu_fpu_flush && (cnt_d != '0)) state_d = DRAIN;
            DRAIN: if (cnt_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[fpu_idu_fwd_dst] <= fpu_idu_fwd_data;
        end
    end

    pa_fpu_wbrf_rdport #(.FLEN(FLEN)) u_rd1 (
        .idx_i    (idu_fpu_rs1_idx),
        .rf_i     (rf_q),
        .busy_i   (busy_q),
        .wb_en_i  (wb_en),
        .wb_dst_i (fpu_idu_fwd_dst),
        .wb_data_i(fpu_idu_fwd_data),
        .data_o   (fpu_idu_rs1_data),
        .busy_o   (fpu_idu_rs1_busy)
    );

    pa_fpu_wbrf_rdport #(.FLEN(FLEN)) u_rd2 (
        .idx_i    (idu_fpu_rs2_idx),
        .rf_i     (rf_q),
        .busy_i   (busy_q),
        .wb_en_i  (wb_en),
        .wb_dst_i (fpu_idu_fwd_dst),
        .wb_data_i(fpu_idu_fwd_data),
        .data_o   (fpu_idu_rs2_data),
        .busy_o   (fpu_idu_rs2_busy)
    );

    pa_fpu_wbrf_rdport #(.FLEN(FLEN)) u_rd3 (
        .idx_i    (idu_fpu_rs3_idx),
        .rf_i     (rf_q),
        .busy_i   (busy_q),
        .wb_en_i  (wb_en),
        .wb_dst_i (fpu_idu_fwd_dst),
        .wb_data_i(fpu_idu_fwd_data),
        .data_o   (fpu_idu_rs3_data),
        .busy_o   (fpu_idu_rs3_busy)
    );

    assign fpu_idu_issue_rdy = rdy;
    assign fpu_csr_fflags    = fflags_q;
    assign fpu_idu_drain     = (state_q == DRAIN);

`ifdef FPU_WBRF_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (wb_en && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign fpu_perf_wb_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pa_fpu_wbrf.sv
// Directed, table-driven bench for pa_fpu_wbrf plus a reset-during-drain sequence.
module tb_pa_fpu_wbrf;

    logic        clk;
    logic        rst_i;
    logic        issue_vld;
    logic [4:0]  issue_dst;
    logic        issue_rdy;
    logic        flush;
    logic        fwd_vld;
    logic [31:0] fwd_data;
    logic [4:0]  fwd_fflags;
    logic [4:0]  fwd_dst;
    logic [4:0]  rs1_idx, rs2_idx, rs3_idx;
    logic [31:0] rs1_data, rs2_data, rs3_data;
    logic        rs1_busy, rs2_busy, rs3_busy;
    logic        csr_wen;
    logic [4:0]  csr_wdata;
    logic [4:0]  fflags;
    logic        drain;
`ifdef FPU_WBRF_PERF_EN
    logic [31:0] perf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pa_fpu_wbrf dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .idu_fpu_issue_vld   (issue_vld),
        .idu_fpu_issue_dst   (issue_dst),
        .fpu_idu_issue_rdy   (issue_rdy),
        .idu_fpu_flush       (flush),
        .fpu_idu_fwd_vld     (fwd_vld),
        .fpu_idu_fwd_data    (fwd_data),
        .fpu_idu_fwd_fflags  (fwd_fflags),
        .fpu_idu_fwd_dst     (fwd_dst),
        .idu_fpu_rs1_idx     (rs1_idx),
        .idu_fpu_rs2_idx     (rs2_idx),
        .idu_fpu_rs3_idx     (rs3_idx),
        .fpu_idu_rs1_data    (rs1_data),
        .fpu_idu_rs2_data    (rs2_data),
        .fpu_idu_rs3_data    (rs3_data),
        .fpu_idu_rs1_busy    (rs1_busy),
        .fpu_idu_rs2_busy    (rs2_busy),
        .fpu_idu_rs3_busy    (rs3_busy),
        .csr_fpu_fflags_wen  (csr_wen),
        .csr_fpu_fflags_wdata(csr_wdata),
        .fpu_csr_fflags      (fflags),
        .fpu_idu_drain       (drain)
`ifdef FPU_WBRF_PERF_EN
        ,
        .fpu_perf_wb_cnt     (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs: iv id fl fv fd ff fdst cw cd r1 r2 r3 ; expected: rdy drain fflags d1 b1 d2 b2 d3 b3
    typedef struct {
        logic        iv;
        logic [4:0]  id;
        logic        fl;
        logic        fv;
        logic [31:0] fd;
        logic [4:0]  ff;
        logic [4:0]  fdst;
        logic        cw;
        logic [4:0]  cd;
        logic [4:0]  r1, r2, r3;
        logic        e_rdy;
        logic        e_drain;
        logic [4:0]  e_ff;
        logic [31:0] e_d1;
        logic        e_b1;
        logic [31:0] e_d2;
        logic        e_b2;
        logic [31:0] e_d3;
        logic        e_b3;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_vld = 0; issue_dst = 0; flush = 0;
        fwd_vld = 0; fwd_data = 0; fwd_fflags = 0; fwd_dst = 0;
        csr_wen = 0; csr_wdata = 0;
        rs1_idx = 0; rs2_idx = 0; rs3_idx = 0;
    endtask

    task automatic apply(input vec_t v);
        issue_vld = v.iv; issue_dst = v.id; flush = v.fl;
        fwd_vld = v.fv; fwd_data = v.fd; fwd_fflags = v.ff; fwd_dst = v.fdst;
        csr_wen = v.cw; csr_wdata = v.cd;
        rs1_idx = v.r1; rs2_idx = v.r2; rs3_idx = v.r3;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d rdy", i),    32'(issue_rdy), 32'(v.e_rdy));
        chk($sformatf("v%0d drain", i),  32'(drain),     32'(v.e_drain));
        chk($sformatf("v%0d fflags", i), 32'(fflags),    32'(v.e_ff));
        chk($sformatf("v%0d rs1_data", i), rs1_data,     v.e_d1);
        chk($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(v.e_b1));
        chk($sformatf("v%0d rs2_data", i), rs2_data,     v.e_d2);
        chk($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(v.e_b2));
        chk($sformatf("v%0d rs3_data", i), rs3_data,     v.e_d3);
        chk($sformatf("v%0d rs3_busy", i), 32'(rs3_busy), 32'(v.e_b3));
    endtask

    initial begin
        //               iv id  fl fv fd            ff     fdst cw cd    r1  r2  r3   rdy dr ff     d1            b1 d2            b2 d3            b3
        vecs.push_back('{0, 0,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 0,  0,  0,   1,  0, 5'h00, 32'h0,        0, 32'h0,        0, 32'h0,        0}); // 0 reset values
        vecs.push_back('{1, 5,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 5,  0,  0,   1,  0, 5'h00, 32'h0,        0, 32'h0,        0, 32'h0,        0}); // 1 issue f5
        vecs.push_back('{0, 5,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 5,  0,  0,   0,  0, 5'h00, 32'h0,        1, 32'h0,        0, 32'h0,        0}); // 2 f5 busy
        vecs.push_back('{0, 0,  0, 1, 32'h3F800000, 5'h01, 5,   0, 5'h0, 5,  0,  0,   1,  0, 5'h00, 32'h3F800000, 0, 32'h0,        0, 32'h0,        0}); // 3 wb f5 bypass
        vecs.push_back('{0, 0,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 5,  7,  5,   1,  0, 5'h01, 32'h3F800000, 0, 32'h0,        0, 32'h3F800000, 0}); // 4 f5 written
        vecs.push_back('{1, 7,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 5,  7,  0,   1,  0, 5'h01, 32'h3F800000, 0, 32'h0,        0, 32'h0,        0}); // 5 issue f7
        vecs.push_back('{0, 0,  0, 1, 32'h40000000, 5'h00, 7,   0, 5'h0, 5,  7,  7,   1,  0, 5'h01, 32'h3F800000, 0, 32'h40000000, 0, 32'h40000000, 0}); // 6 bypass f7
        vecs.push_back('{1, 1,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 7,  7,  0,   1,  0, 5'h01, 32'h40000000, 0, 32'h40000000, 0, 32'h0,        0}); // 7 issue f1
        vecs.push_back('{1, 2,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 1,  0,  0,   1,  0, 5'h01, 32'h0,        1, 32'h0,        0, 32'h0,        0}); // 8 issue f2
        vecs.push_back('{1, 3,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 2,  0,  0,   1,  0, 5'h01, 32'h0,        1, 32'h0,        0, 32'h0,        0}); // 9 issue f3
        vecs.push_back('{1, 4,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 3,  0,  0,   1,  0, 5'h01, 32'h0,        1, 32'h0,        0, 32'h0,        0}); // 10 issue f4, cnt=4
        vecs.push_back('{1, 9,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 1,  4,  9,   0,  0, 5'h01, 32'h0,        1, 32'h0,        1, 32'h0,        0}); // 11 full
        vecs.push_back('{1, 9,  0, 1, 32'h11111111, 5'h00, 1,   0, 5'h0, 1,  4,  9,   0,  0, 5'h01, 32'h11111111, 0, 32'h0,        1, 32'h0,        0}); // 12 wb f1, still cnt=4
        vecs.push_back('{1, 9,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 1,  4,  9,   1,  0, 5'h01, 32'h11111111, 0, 32'h0,        1, 32'h0,        0}); // 13 issue f9
        vecs.push_back('{1, 9,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 2,  3,  9,   0,  0, 5'h01, 32'h0,        1, 32'h0,        1, 32'h0,        1}); // 14 full again
        vecs.push_back('{0, 0,  0, 1, 32'h22222222, 5'h00, 2,   0, 5'h0, 2,  3,  9,   0,  0, 5'h01, 32'h22222222, 0, 32'h0,        1, 32'h0,        1}); // 15 wb f2
        vecs.push_back('{0, 3,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 2,  3,  9,   0,  0, 5'h01, 32'h22222222, 0, 32'h0,        1, 32'h0,        1}); // 16 WAW stall f3
        vecs.push_back('{1, 3,  0, 1, 32'h33333333, 5'h04, 3,   0, 5'h0, 2,  3,  9,   1,  0, 5'h01, 32'h22222222, 0, 32'h33333333, 0, 32'h0,        1}); // 17 WAW lifts
        vecs.push_back('{0, 3,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 4,  3,  9,   0,  0, 5'h05, 32'h0,        1, 32'h33333333, 1, 32'h0,        1}); // 18 set wins
        vecs.push_back('{0, 0,  0, 0, 32'h0,        5'h00, 0,   1, 5'h1, 4,  3,  9,   1,  0, 5'h05, 32'h0,        1, 32'h33333333, 1, 32'h0,        1}); // 19 csr=0x01
        vecs.push_back('{0, 0,  0, 1, 32'h44444444, 5'h04, 4,   1, 5'h0, 4,  3,  9,   1,  0, 5'h01, 32'h44444444, 0, 32'h33333333, 1, 32'h0,        1}); // 20 csr=0 | 0x04
        vecs.push_back('{1, 10, 1, 0, 32'h0,        5'h00, 0,   0, 5'h0, 3,  6,  9,   0,  0, 5'h04, 32'h33333333, 1, 32'h0,        0, 32'h0,        1}); // 21 flush cnt=2
        vecs.push_back('{1, 10, 0, 1, 32'h0000DEAD, 5'h10, 6,   0, 5'h0, 3,  6,  9,   0,  1, 5'h04, 32'h33333333, 0, 32'h0,        0, 32'h0,        0}); // 22 drain result
        vecs.push_back('{0, 10, 1, 1, 32'h0000DEAD, 5'h10, 6,   0, 5'h0, 3,  6,  9,   0,  1, 5'h04, 32'h33333333, 0, 32'h0,        0, 32'h0,        0}); // 23 last result
        vecs.push_back('{0, 10, 0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 3,  6,  9,   1,  0, 5'h04, 32'h33333333, 0, 32'h0,        0, 32'h0,        0}); // 24 back to idle
        vecs.push_back('{1, 11, 1, 0, 32'h0,        5'h00, 0,   0, 5'h0, 3,  6,  9,   0,  0, 5'h04, 32'h33333333, 0, 32'h0,        0, 32'h0,        0}); // 25 flush cnt=0
        vecs.push_back('{1, 11, 0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 3,  6,  11,  1,  0, 5'h04, 32'h33333333, 0, 32'h0,        0, 32'h0,        0}); // 26 issue f11
        vecs.push_back('{0, 11, 0, 1, 32'h5A5A5A5A, 5'h00, 0,   0, 5'h0, 11, 6,  0,   0,  0, 5'h04, 32'h0,        1, 32'h0,        0, 32'h5A5A5A5A, 0}); // 27 f0 writable
        vecs.push_back('{0, 11, 0, 1, 32'hA5A5A5A5, 5'h02, 11,  0, 5'h0, 11, 0,  0,   1,  0, 5'h04, 32'hA5A5A5A5, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0}); // 28 wb at cnt=0
        vecs.push_back('{0, 0,  0, 0, 32'h0,        5'h00, 0,   0, 5'h0, 11, 0,  0,   1,  0, 5'h06, 32'hA5A5A5A5, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 0}); // 29 cnt saturated

        drive_idle();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end

        // Two ops in flight, flush into DRAIN, then reset asynchronously mid-drain.
        @(negedge clk);
        drive_idle();
        rs1_idx = 5; rs2_idx = 12;
        issue_vld = 1; issue_dst = 12;
        #1 chk("seq issue12 rdy", 32'(issue_rdy), 32'd1);
        @(negedge clk);
        issue_dst = 13;
        #1 chk("seq issue13 rdy", 32'(issue_rdy), 32'd1);
        @(negedge clk);
        issue_vld = 0; issue_dst = 0; flush = 1;
        #1 chk("seq flush drain", 32'(drain), 32'd0);
        @(negedge clk);
        flush = 0;
        #1;
        chk("seq in drain", 32'(drain), 32'd1);
        chk("seq drain rdy", 32'(issue_rdy), 32'd0);
        chk("seq drain rs1_data", rs1_data, 32'h3F800000);
        #2 rst_i = 1'b1;
        #1;
        chk("seq rst drain", 32'(drain), 32'd0);
        chk("seq rst rdy", 32'(issue_rdy), 32'd1);
        chk("seq rst fflags", 32'(fflags), 32'd0);
        chk("seq rst rs1_data", rs1_data, 32'h0);
        chk("seq rst rs2_busy", 32'(rs2_busy), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        chk("seq post drain", 32'(drain), 32'd0);
        chk("seq post rdy", 32'(issue_rdy), 32'd1);
        chk("seq post rs1_data", rs1_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
